// File: rtl/alu_seq.sv
// alu_seq: single-operation ALU with a valid/ready handshake on each side.
// Most ops finish one cycle after accept; mul/divu/remu run an iterative
// shift-add or restoring-divide loop for D_WIDTH cycles.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// CALC  | iterating mul/div, one step per cycle
// DONE  | result presented, waiting for out_ready
module alu_seq #(
  parameter int D_WIDTH   = 32,
  parameter int MULDIV_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               alusrc,
  input  logic [3:0]         aluctrl,
  input  logic [D_WIDTH-1:0] aluop1,
  input  logic [D_WIDTH-1:0] immop,
  input  logic [D_WIDTH-1:0] regop2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] aluout,
  output logic               eq,
  output logic               lt,
  output logic               ltu
);

  localparam int SW = $clog2(D_WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [3:0]         ctrl_q;
  logic [D_WIDTH-1:0] a_q, b_q, acc_q;
  logic [D_WIDTH-1:0] a_nx, b_nx, acc_nx;
  logic [D_WIDTH:0]   rem_sh;
  logic [D_WIDTH-1:0] op2;
  logic [D_WIDTH-1:0] fast_res;
  logic [SW-1:0]      shamt;
  logic               accept;
  logic               is_md;
  logic               last_step;

  assign op2       = alusrc ? immop : regop2;
  assign shamt     = op2[SW-1:0];
  assign accept    = in_valid && in_ready;
  assign is_md     = (MULDIV_EN != 0) && (aluctrl >= 4'd10) && (aluctrl <= 4'd12);
  assign last_step = (cnt == CW'(D_WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = is_md ? CALC : DONE;
      end
      CALC: begin
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Single-cycle result straight from the request operands
  always_comb begin
    fast_res = '0;
    case (aluctrl)
      4'd0: fast_res = aluop1 + op2;
      4'd1: fast_res = aluop1 - op2;
      4'd2: fast_res = aluop1 & op2;
      4'd3: fast_res = aluop1 | op2;
      4'd4: fast_res = aluop1 ^ op2;
      4'd5: fast_res = aluop1 << shamt;
      4'd6: fast_res = aluop1 >> shamt;
      4'd7: fast_res = D_WIDTH'($signed(aluop1) >>> shamt);
      4'd8: fast_res = {{(D_WIDTH-1){1'b0}}, ($signed(aluop1) < $signed(op2))};
      4'd9: fast_res = {{(D_WIDTH-1){1'b0}}, (aluop1 < op2)};
      default: fast_res = '0;
    endcase
  end

  // One mul (shift-add) or divide (restoring subtract) step.
  // Divide: a_q shifts the dividend out and the quotient in; acc_q is the
  // partial remainder. A zero divisor always "subtracts", which naturally
  // yields an all-ones quotient and remainder equal to the dividend.
  always_comb begin
    a_nx   = a_q;
    b_nx   = b_q;
    acc_nx = acc_q;
    rem_sh = {acc_q, a_q[D_WIDTH-1]};
    if (ctrl_q == 4'd10) begin
      if (b_q[0]) acc_nx = acc_q + a_q;
      a_nx = a_q << 1;
      b_nx = b_q >> 1;
    end else if (rem_sh >= {1'b0, b_q}) begin
      acc_nx = D_WIDTH'(rem_sh - {1'b0, b_q});
      a_nx   = {a_q[D_WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = rem_sh[D_WIDTH-1:0];
      a_nx   = {a_q[D_WIDTH-2:0], 1'b0};
    end
  end

  // Operand capture, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt    <= '0;
      aluout <= '0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      ltu    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ctrl_q <= aluctrl;
            a_q    <= aluop1;
            b_q    <= op2;
            acc_q  <= '0;
            cnt    <= '0;
            eq     <= (aluop1 == op2);
            lt     <= ($signed(aluop1) < $signed(op2));
            ltu    <= (aluop1 < op2);
            if (!is_md) aluout <= fast_res;
          end
        end
        CALC: begin
          a_q   <= a_nx;
          b_q   <= b_nx;
          acc_q <= acc_nx;
          cnt   <= cnt + 1'b1;
          if (last_step) aluout <= (ctrl_q == 4'd11) ? a_nx : acc_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, the operand/result width; legal values are powers of 2 from 8 to 64.
REQ-002 SHALL have parameter MULDIV_EN, default 1; when 1 the iterative mul/divu/remu unit is present.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  the request is valid.
REQ-006 SHALL have port in_ready  output  1  the block can accept a request.
REQ-007 SHALL have port alusrc  input  1  operand-2 select: 1=immop, 0=regop2.
REQ-008 SHALL have port aluctrl  input  4  operation code.
REQ-009 SHALL have ports aluop1, immop, regop2  input  D_WIDTH  operands.
REQ-010 SHALL have port out_valid  output  1  the result is valid.
REQ-011 SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-012 SHALL have port aluout  output  D_WIDTH  the result.
REQ-013 SHALL have ports eq, lt, ltu  output  1 each  op1==op2, signed op1<op2, unsigned op1<op2.

Function
REQ-014 SHALL form op2 = alusrc ? immop : regop2 and capture op1, op2 and aluctrl on the accept cycle (in_valid && in_ready); it SHALL not sample the inputs at any other time.
REQ-015 SHALL implement the following aluctrl codes: 0 add; 1 sub; 2 and; 3 or; 4 xor; 5 sll; 6 srl; 7 sra; 8 slt; 9 sltu; 10 mul (low D_WIDTH bits); 11 divu; 12 remu; 13-15 result 0.
REQ-016 SHALL make add/sub wrap modulo 2^D_WIDTH; shifts SHALL use only op2[log2(D_WIDTH)-1:0]; slt/sltu SHALL return 1 or 0 zero-extended.
REQ-017 SHALL use an FSM with the states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 SHALL go IDLE->DONE on accepting codes 0-9 or 13-15, with the result registered, giving out_valid on the cycle after accept (latency 1).
REQ-019 SHALL go IDLE->CALC on accepting codes 10-12, then run one shift-add (mul) or restoring-subtract (div) step per cycle for exactly D_WIDTH cycles, then go CALC->DONE; out_valid SHALL rise D_WIDTH+1 cycles after accept.
REQ-020 SHALL treat codes 10-12 as single-cycle with result 0 when MULDIV_EN=0.
REQ-021 SHALL, on divu with op2=0, return all ones; on remu with op2=0, SHALL return op1; neither case SHALL trap or shorten latency.
REQ-022 SHALL hold aluout, eq, lt and ltu stable while in DONE; on DONE with out_ready=1 it SHALL go to IDLE (in_ready rises the next cycle, so there is no same-cycle accept).
REQ-023 SHALL register eq, lt and ltu from the captured operands and make them valid with out_valid for every opcode.
REQ-024 SHALL ignore in_valid in CALC and DONE, and SHALL ignore out_ready in IDLE and CALC.
REQ-025 SHALL hold the step counter at log2(D_WIDTH)+1 bits, clear it on CALC entry, and leave CALC when it reaches D_WIDTH-1.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, go to IDLE from any state (including mid-CALC, aborting the operation) and clear aluout, eq, lt, ltu, out_valid and the counter to 0.
REQ-027 SHALL drive in_ready=1 in the first cycle after rst deasserts; rst SHALL take priority over a simultaneous in_valid.

Verification
REQ-028 SHALL be checked by: add, op1=0xFFFFFFFF, regop2=1, alusrc=0 -> aluout=0, eq=0, ltu=0, lt=1, out_valid one cycle after accept.
REQ-029 SHALL be checked by: sra, op1=0x80000000, immop=0x24, alusrc=1 -> shift by 4, aluout=0xF8000000.
REQ-030 SHALL be checked by: mul, 0x0001_0000 x 0x0001_0003 -> aluout=0x0003_0000, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-031 SHALL be checked by: divu 100/7 -> 14; remu 100/7 -> 2; divu x/0 -> 0xFFFFFFFF; remu 5/0 -> 5.
REQ-032 SHALL be checked by: out_ready held 0 for 10 cycles in DONE -> aluout stable and in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 SHALL be checked by: rst pulsed at CALC step 12 of a divu -> all outputs 0 and in_ready=1 next cycle; a following add of 2+3 -> 5.
